// File: rtl/button_conditioner.sv
// Synchronises, debounces and pulse-shapes the three game buttons (bit0 drop, bit1 right, bit2 left).
// Right/left auto-repeat while held; simultaneous right+left pulses cancel each other.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 10000000,
  parameter int unsigned REPEAT_PERIOD   = 3750000,
  parameter logic [2:0]  REPEAT_MASK     = 3'b110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn_raw,
  output logic [2:0] btn_level,
  output logic [2:0] btn_press
);

  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST  = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RC_SAT   = {RW{1'b1}};

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  logic [2:0]    s1, s2;
  logic [CW-1:0] cnt     [3];
  logic [CW-1:0] cnt_nxt [3];
  logic [RW-1:0] rc      [3];
  logic [RW-1:0] rc_nxt  [3];
  state_t        st      [3];
  state_t        st_nxt  [3];
  logic [2:0]    level_nxt;
  logic [2:0]    pulse;
  logic [2:0]    press_nxt;
  logic          conflict;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_nxt[i]   = cnt[i];
      rc_nxt[i]    = rc[i];
      st_nxt[i]    = st[i];
      level_nxt[i] = btn_level[i];
      pulse[i]     = 1'b0;

      if (s2[i] == btn_level[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == DB_LAST) begin
        level_nxt[i] = s2[i];
        cnt_nxt[i]   = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end

      // The pulse is decided from the next level so it registers alongside the level change.
      case (st[i])
        IDLE: begin
          if (level_nxt[i] && !btn_level[i]) begin
            st_nxt[i] = HELD;
            pulse[i]  = 1'b1;
            rc_nxt[i] = '0;
          end
        end
        HELD: begin
          if (!level_nxt[i]) begin
            st_nxt[i] = IDLE;
            rc_nxt[i] = '0;
          end else if (REPEAT_MASK[i] && rc[i] == RD_LAST) begin
            st_nxt[i] = REPEAT;
            pulse[i]  = 1'b1;
            rc_nxt[i] = '0;
          end else if (rc[i] != RC_SAT) begin
            rc_nxt[i] = rc[i] + RW'(1);
          end
        end
        REPEAT: begin
          if (!level_nxt[i]) begin
            st_nxt[i] = IDLE;
            rc_nxt[i] = '0;
          end else if (rc[i] == RP_LAST) begin
            pulse[i]  = 1'b1;
            rc_nxt[i] = '0;
          end else if (rc[i] != RC_SAT) begin
            rc_nxt[i] = rc[i] + RW'(1);
          end
        end
        default: begin
          st_nxt[i] = IDLE;
          rc_nxt[i] = '0;
        end
      endcase
    end

    // FSMs still advance on a cancelled pulse, so a held pair stays in lockstep and keeps cancelling.
    conflict  = pulse[1] & pulse[2];
    press_nxt = pulse & ~{conflict, conflict, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      btn_level <= '0;
      btn_press <= '0;
      cnt       <= '{default: '0};
      rc        <= '{default: '0};
      st        <= '{default: IDLE};
    end else begin
      s1        <= btn_raw;
      s2        <= s1;
      btn_level <= level_nxt;
      btn_press <= press_nxt;
      cnt       <= cnt_nxt;
      rc        <= rc_nxt;
      st        <= st_nxt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: stimulus pushes expected (edge, press bits); a negedge monitor pops on every pulse.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_press;

  typedef struct {
    int unsigned e;
    logic [2:0]  b;
  } exp_t;

  exp_t        q[$];
  int unsigned edge_n;
  int          checks;
  int          errors;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_MASK    (3'b110)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int unsigned e, input logic [2:0] b);
    exp_t x;
    x.e = e;
    x.b = b;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: every nonzero press must match the head of the scoreboard in both edge and bits.
  always @(negedge clk) begin
    if (btn_press !== 3'b000) begin
      exp_t x;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_press got bits %b at edge %0d expected none", btn_press, edge_n);
      end else begin
        x = q.pop_front();
        if (x.e != edge_n || x.b !== btn_press) begin
          errors++;
          $display("FAIL press got edge %0d bits %b expected edge %0d bits %b",
                   edge_n, btn_press, x.e, x.b);
        end
      end
    end
  end

  initial begin
    int unsigned m;
    int unsigned e;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    btn_raw = 3'b000;
    tick(3);
    chk("reset_level", btn_level, 3'b000);
    chk("reset_press", btn_press, 3'b000);
    rst_n = 1'b1;
    tick(2);

    // 1: drop button, clean press, no repeats, level falls 5 edges after the release is sampled
    btn_raw[0] = 1'b1;
    m = edge_n;
    push(m + 6, 3'b001);
    tick(50);
    chk("t1_level_held", btn_level, 3'b001);
    btn_raw[0] = 1'b0;
    tick(5);
    chk("t1_level_before_fall", btn_level, 3'b001);
    tick(1);
    chk("t1_level_after_fall", btn_level, 3'b000);
    tick(5);

    // 2: bouncing right button, single pulse after the final rise
    for (int c = 0; c < 5; c++) begin
      btn_raw[1] = 1'b1;
      tick(2);
      btn_raw[1] = 1'b0;
      tick(2);
    end
    chk("t2_level_bounce", btn_level, 3'b000);
    btn_raw[1] = 1'b1;
    m = edge_n;
    push(m + 6, 3'b010);
    tick(8);
    btn_raw[1] = 1'b0;
    tick(12);

    // 3: left auto-repeat; the slot coinciding with the falling level must not pulse
    btn_raw[2] = 1'b1;
    m = edge_n;
    push(m + 6, 3'b100);
    for (int unsigned p = m + 16; p < m + 46; p += 3) push(p, 3'b100);
    tick(40);
    btn_raw[2] = 1'b0;
    tick(12);
    chk("t3_level_released", btn_level, 3'b000);

    // 4: right and left together: levels rise, every pulse cancels
    btn_raw = 3'b110;
    tick(30);
    chk("t4_level_both", btn_level, 3'b110);
    btn_raw = 3'b000;
    tick(12);

    // 5: glitch shorter than the debounce window
    btn_raw[0] = 1'b1;
    tick(3);
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (i == 4) chk("t5_level_glitch", btn_level, 3'b000);
    end

    // 6: reset while left is repeating, then treated as a fresh press
    btn_raw[2] = 1'b1;
    m = edge_n;
    push(m + 6, 3'b100);
    push(m + 16, 3'b100);
    push(m + 19, 3'b100);
    tick(20);
    rst_n = 1'b0;
    tick(1);
    chk("t6_reset_level", btn_level, 3'b000);
    chk("t6_reset_press", btn_press, 3'b000);
    tick(1);
    rst_n = 1'b1;
    e = edge_n + 1;
    push(e + 5, 3'b100);
    tick(10);
    chk("t6_level_after_reset", btn_level, 3'b100);
    btn_raw[2] = 1'b0;
    tick(12);

    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_press got none expected edge %0d bits %b", x.e, x.b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
